// File: rtl/stim_generator.sv
// Stimulus vector generator: issues NUM_TESTS words (ramp, LFSR, constant or alternate)
// over a valid/ready handshake, one word per cycle when the consumer keeps up.
module stim_generator #(
  parameter int NUM_TESTS  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  localparam logic [DATA_WIDTH-1:0] LFSR_POLY = DATA_WIDTH'(32'h8020_0003);
  localparam logic [15:0]           LAST_IDX  = 16'(NUM_TESTS - 1);

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [DATA_WIDTH-1:0] r_step;
  logic                  w_xfer;
  logic                  w_last;

  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : '0);
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed starts from 1.
  function automatic logic [DATA_WIDTH-1:0] first_value(input logic [1:0] m,
                                                        input logic [DATA_WIDTH-1:0] sd);
    if (m == MODE_LFSR && sd == '0)
      return DATA_WIDTH'(1);
    return sd;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_value(input logic [1:0]            m,
                                                       input logic [DATA_WIDTH-1:0] cur,
                                                       input logic [DATA_WIDTH-1:0] st);
    case (m)
      MODE_RAMP:  return cur + st;
      MODE_LFSR:  return lfsr_next(cur);
      MODE_CONST: return cur;
      MODE_ALT:   return ~cur;
      default:    return cur;
    endcase
  endfunction

  assign w_xfer = out_valid & out_ready;
  assign w_last = (out_index == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_seed    <= '0;
      r_step    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_mode    <= mode;
            r_seed    <= seed;
            r_step    <= step;
            out_data  <= first_value(mode, seed);
            out_index <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state   <= S_DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_index <= out_index + 16'd1;
              out_data  <= next_value(r_mode, out_data, r_step);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_generator.sv
// Randomized bench for stim_generator; expected words come from the closed-form pattern rules.
module tb_stim_generator;

  localparam int N     = 16;
  localparam int BOUND = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = 32'd0;
  logic [31:0] step = 32'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_index;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  stim_generator #(.NUM_TESTS(N), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .step      (step),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Value of vector i computed straight from the pattern definitions.
  function automatic logic [31:0] ref_value(input logic [1:0] m, input logic [31:0] sd,
                                            input logic [31:0] st, input int i);
    logic [31:0] x;
    case (m)
      2'd0: return sd + st * 32'(i);
      2'd1: begin
        x = (sd == 32'd0) ? 32'd1 : sd;
        for (int k = 0; k < i; k++)
          x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return x;
      end
      2'd2: return sd;
      default: return (i % 2 == 1) ? ~sd : sd;
    endcase
  endfunction

  // rdy_kind: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // rst_after >= 0 aborts the run with reset right after that index transfers.
  // spur_idx >= 0 pulses start with another mode while that index is presented.
  task automatic run_test(input logic [1:0] m, input logic [31:0] sd, input logic [31:0] st,
                          input int rdy_kind, input int rst_after, input int spur_idx);
    int  xfers;
    int  cyc;
    bit  rdy;
    @(negedge clk);
    mode  = m;
    seed  = sd;
    step  = st;
    start = 1'b1;
    xfers = 0;
    cyc   = 0;
    while (xfers < N && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      case (rdy_kind)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      start = (spur_idx >= 0 && xfers == spur_idx);
      if (cyc == 1 || start) begin
        mode = m + 2'd1;
        seed = $urandom;
        step = $urandom;
      end
      check_eq("valid", 64'(out_valid), 64'd1);
      check_eq("busy", 64'(busy), 64'd1);
      check_eq("done_early", 64'(done), 64'd0);
      check_eq("index", 64'(out_index), 64'(xfers));
      check_eq("data", 64'(out_data), 64'(ref_value(m, sd, st, xfers)));
      if (rdy) begin
        xfers++;
        if (rst_after >= 0 && xfers == rst_after + 1) begin
          @(posedge clk);
          #2 rst = 1'b1;
          #1;
          check_eq("rst_valid", 64'(out_valid), 64'd0);
          check_eq("rst_data", 64'(out_data), 64'd0);
          check_eq("rst_index", 64'(out_index), 64'd0);
          check_eq("rst_busy", 64'(busy), 64'd0);
          check_eq("rst_done", 64'(done), 64'd0);
          @(negedge clk);
          check_eq("rst_no_done", 64'(done), 64'd0);
          start = 1'b0;
          out_ready = 1'b0;
          rst = 1'b0;
          return;
        end
      end
    end
    start = 1'b0;
    if (xfers < N) check_eq("timeout", 64'(xfers), 64'(N));
    @(negedge clk);
    check_eq("end_valid", 64'(out_valid), 64'd0);
    check_eq("end_busy", 64'(busy), 64'd0);
    check_eq("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check_eq("done_single", 64'(done), 64'd0);
    check_eq("idle_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    check_eq("reset_valid", 64'(out_valid), 64'd0);
    check_eq("reset_data", 64'(out_data), 64'd0);
    check_eq("reset_index", 64'(out_index), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_test(2'd0, 32'h10, 32'h4, 0, -1, -1);
    run_test(2'd1, 32'h0, 32'h0, 0, -1, -1);
    run_test(2'd0, 32'h0, 32'h1, 1, -1, -1);
    run_test(2'd0, 32'hFFFF_FFFE, 32'h1, 0, -1, -1);
    run_test(2'd3, 32'h0000_FFFF, 32'h0, 0, -1, -1);
    run_test(2'd2, 32'hA5A5_1234, 32'h7, 2, -1, -1);
    run_test(2'd0, 32'h100, 32'h3, 0, 5, -1);
    run_test(2'd0, 32'h100, 32'h3, 0, -1, -1);
    run_test(2'd0, 32'h55, 32'h11, 0, -1, 3);
    for (int t = 0; t < 8; t++)
      run_test(2'($urandom_range(0, 3)), $urandom, $urandom, 2, -1,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stim_generator.md
STIM_GENERATOR -- requirements
Module: stim_generator

Interface
REQ-001 Parameter NUM_TESTS, default 16: number of vectors issued per run; legal range 1..65535.
REQ-002 Parameter DATA_WIDTH, default 32: stimulus word width; fixed at 32 for LFSR mode.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: begin a run; sampled only in IDLE.
REQ-006 Port mode, input, 2: pattern select, latched at start (0 ramp, 1 LFSR, 2 constant, 3 alternate).
REQ-007 Port seed, input, 32: initial value, latched at start.
REQ-008 Port step, input, 32: ramp increment, latched at start.
REQ-009 Port out_data, output, 32: current stimulus word.
REQ-010 Port out_valid, output, 1: out_data/out_index valid.
REQ-011 Port out_ready, input, 1: consumer accepts word.
REQ-012 Port out_index, output, 16: zero-based index of the current vector.
REQ-013 Port busy, output, 1: high in RUN.
REQ-014 Port done, output, 1: one-cycle pulse after the last transfer.

Function
REQ-015 The FSM shall have states IDLE, RUN and DONE.
REQ-016 IDLE->RUN on start=1: latch mode/seed/step, load out_data with the first pattern value, out_index=0; out_valid=1 in the following cycle (one-cycle start latency).
REQ-017 Transfer shall occur only on a rising edge with out_valid=1 and out_ready=1.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_index shall hold stable; out_valid shall not drop.
REQ-019 On each transfer with out_index < NUM_TESTS-1, out_index shall increment and out_data shall advance to the next value in the same edge; out_valid stays 1 (back-to-back, one word per cycle).
REQ-020 On the transfer with out_index = NUM_TESTS-1: RUN->DONE, out_valid=0 next cycle.
REQ-021 DONE shall assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-022 start shall be ignored in RUN and DONE; start held high in IDLE after DONE shall begin a new run.
REQ-023 Ramp: value(i) = seed + i*step, modulo 2^32 (wrap silently).
REQ-024 LFSR: Galois right-shift; next = (x>>1) XOR 0x80200003 when x[0]=1, else x>>1; value(0) = seed, with seed 0 replaced by 1.
REQ-025 Constant: every value = seed.
REQ-026 Alternate: even indices = seed, odd indices = bitwise NOT seed.
REQ-027 busy shall equal (state==RUN); out_valid shall never be high outside RUN.
REQ-028 mode/seed/step changes during RUN shall have no effect until the next start.

Reset
REQ-029 rst=1 shall immediately force state IDLE, out_valid=0, out_data=0, out_index=0, busy=0, done=0, latched mode/seed/step=0.
REQ-030 Reset asserted mid-run shall abort the run with no done pulse; after release, the next run shall restart at index 0.
REQ-031 Release of rst shall be treated as synchronous to clk; first start is accepted on the first rising edge after release.

Verification
REQ-032 Ramp: mode=0, seed=0x10, step=0x4, out_ready=1 -> out_data 0x10,0x14,...,0x4C over 16 consecutive cycles, indices 0..15, single done pulse one cycle after index 15.
REQ-033 LFSR: mode=1, seed=0 -> first three words 0x00000001, 0x80200003, 0xC0300002.
REQ-034 Backpressure: ramp seed=0, step=1, out_ready toggling 1,0,0,1... -> no word dropped or duplicated, out_data stable during stalls, 16 transfers total.
REQ-035 Wrap and alternate: ramp seed=0xFFFFFFFE, step=1 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; mode=3, seed=0x0000FFFF -> 0x0000FFFF, 0xFFFF0000, repeating.
REQ-036 Reset mid-run: assert rst after index 5 transfer -> all outputs 0 within the same cycle, no done; new start restarts at index 0 with value seed.
REQ-037 Start during run: pulse start at index 3 with a different mode -> sequence unaffected, exactly 16 transfers.
